// File: rtl/riscv_rsb.sv
// Return stack buffer: predicts return addresses by decoding calls/returns at fetch.
// Circular buffer that overwrites its oldest entry on overflow; outputs come straight from registered state.
module riscv_rsb #(
    parameter int XLEN      = 32,
    parameter int RSB_DEPTH = 4,
    parameter int HAS_RVC   = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_insn_i,
    output logic [XLEN-1:0] rsb_pc_o,
    output logic            rsb_valid_o
);

    localparam int PW = (RSB_DEPTH > 1) ? $clog2(RSB_DEPTH) : 1;
    localparam int CW = $clog2(RSB_DEPTH + 1);

    logic [XLEN-1:0] entries [RSB_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;

    logic            do_push;
    logic            do_pop;
    logic            fire;
    logic            is_16;
    logic [XLEN-1:0] ret_addr;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic            unused_insn;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    assign unused_insn = ^if_insn_i[31:20];

    assign is_16    = (if_insn_i[1:0] != 2'b11);
    assign ret_addr = if_pc_i + (is_16 ? XLEN'(2) : XLEN'(4));
    assign fire     = if_valid_i & ~stall_i & ~flush_i;

    assign ptr_inc = (ptr == PW'(RSB_DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PW'(RSB_DEPTH - 1) : ptr - PW'(1);

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!is_16) begin
            if (if_insn_i[6:0] == 7'b1101111) begin
                do_push = is_link(if_insn_i[11:7]);
            end else if (if_insn_i[6:0] == 7'b1100111) begin
                case ({is_link(if_insn_i[11:7]), is_link(if_insn_i[19:15])})
                    2'b10: do_push = 1'b1;
                    2'b01: do_pop  = 1'b1;
                    2'b11: begin
                        // Same link register on both sides is a call, not a coroutine swap.
                        do_push = 1'b1;
                        do_pop  = (if_insn_i[11:7] != if_insn_i[19:15]);
                    end
                    default: ;
                endcase
            end
        end else if (HAS_RVC != 0) begin
            if ((XLEN == 32) && (if_insn_i[15:13] == 3'b001) && (if_insn_i[1:0] == 2'b01)) begin
                do_push = 1'b1;
            end else if ((if_insn_i[15:13] == 3'b100) && (if_insn_i[6:2] == 5'd0) &&
                         (if_insn_i[11:7] != 5'd0) && (if_insn_i[1:0] == 2'b10)) begin
                if (if_insn_i[12]) begin
                    do_push = 1'b1;
                    do_pop  = is_link(if_insn_i[11:7]);
                end else begin
                    do_pop  = is_link(if_insn_i[11:7]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RSB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (fire) begin
            if (do_push && do_pop && (count != '0)) begin
                entries[ptr] <= ret_addr;
            end else if (do_push) begin
                // When full, advancing the pointer lands on the oldest entry.
                ptr              <= ptr_inc;
                entries[ptr_inc] <= ret_addr;
                if (count != CW'(RSB_DEPTH)) begin
                    count <= count + CW'(1);
                end
            end else if (do_pop && (count != '0)) begin
                ptr   <= ptr_dec;
                count <= count - CW'(1);
            end
        end
    end

    assign rsb_valid_o = (count != '0);
    assign rsb_pc_o    = (count != '0) ? entries[ptr] : '0;

endmodule

// File: tb/tb_riscv_rsb.sv
// Directed bench for riscv_rsb: one instance with compressed decode enabled and one without,
// both fed the same fetch stream.
module tb_riscv_rsb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_insn = '0;
    logic [31:0] pc1, pc0;
    logic        v1, v0;

    int tests = 0;
    int failed = 0;

    localparam logic [31:0] JAL_X1      = 32'h0000_00EF;
    localparam logic [31:0] RET         = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] JALR_X5_X1  = 32'h0000_82E7;
    localparam logic [31:0] JALR_X1_X1  = 32'h0000_80E7;
    localparam logic [31:0] JALR_X1_X10 = 32'h0005_00E7;
    localparam logic [31:0] JALR_X10_X5 = 32'h0002_8567;
    localparam logic [31:0] ADDI_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_JAL       = 32'h0000_2001;
    localparam logic [31:0] C_JR_X1     = 32'h0000_8082;
    localparam logic [31:0] C_JALR_X1   = 32'h0000_9082;
    localparam logic [31:0] C_JALR_X10  = 32'h0000_9502;

    always #5 clk = ~clk;

    riscv_rsb #(.XLEN(32), .RSB_DEPTH(4), .HAS_RVC(1)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .if_valid_i(if_valid), .if_pc_i(if_pc), .if_insn_i(if_insn),
        .rsb_pc_o(pc1), .rsb_valid_o(v1)
    );

    riscv_rsb #(.XLEN(32), .RSB_DEPTH(4), .HAS_RVC(0)) dut_norvc (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .if_valid_i(if_valid), .if_pc_i(if_pc), .if_insn_i(if_insn),
        .rsb_pc_o(pc0), .rsb_valid_o(v0)
    );

    task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                         input logic valid, input logic st, input logic fl, input logic rs);
        @(negedge clk);
        if_insn  = insn;
        if_pc    = pc;
        if_valid = valid;
        stall    = st;
        flush    = fl;
        rst      = rs;
        @(posedge clk);
        #1;
        if_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic issue(input logic [31:0] insn, input logic [31:0] pc);
        drive(insn, pc, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(JAL_X1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(JAL_X1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL reset_rvc: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
        tests++;
        if ({v0, pc0} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL reset_norvc: got v=%b pc=%h want v=0 pc=00000000", v0, pc0);
        end
    endtask

    task automatic test_push_pop();
        issue(JAL_X1, 32'h100);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL jal_push: got v=%b pc=%h want v=1 pc=00000104", v1, pc1);
        end
        tests++;
        if ({v0, pc0} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL jal_push_norvc: got v=%b pc=%h want v=1 pc=00000104", v0, pc0);
        end
        issue(RET, 32'h500);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL ret_pop: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_top [4] = '{32'h44, 32'h34, 32'h24, 32'h0};
        for (int i = 1; i <= 5; i++) issue(JAL_X1, 32'(i * 16));
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h54}) begin
            failed++; $display("FAIL ovf_top: got v=%b pc=%h want v=1 pc=00000054", v1, pc1);
        end
        for (int i = 0; i < 4; i++) begin
            issue(RET, 32'h900);
            tests++;
            if ({v1, pc1} !== {(i != 3), exp_top[i]}) begin
                failed++;
                $display("FAIL ovf_pop%0d: got v=%b pc=%h want v=%b pc=%h", i + 1, v1, pc1, (i != 3), exp_top[i]);
            end
        end
        issue(RET, 32'h900);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL ovf_pop5_noop: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
        issue(JAL_X1, 32'h60);
        issue(RET, 32'h900);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL empty_pop_count: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
    endtask

    task automatic test_swap();
        issue(JAL_X1, 32'h100);
        issue(JALR_X5_X1, 32'h200);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h204}) begin
            failed++; $display("FAIL swap_top: got v=%b pc=%h want v=1 pc=00000204", v1, pc1);
        end
        issue(RET, 32'h900);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL swap_count: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
        issue(JALR_X5_X1, 32'h200);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h204}) begin
            failed++; $display("FAIL swap_empty: got v=%b pc=%h want v=1 pc=00000204", v1, pc1);
        end
        issue(RET, 32'h900);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL swap_empty_count: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
    endtask

    task automatic test_jalr_decode();
        issue(JALR_X1_X10, 32'h400);
        issue(JALR_X1_X1, 32'h500);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h504}) begin
            failed++; $display("FAIL jalr_same_link_push: got v=%b pc=%h want v=1 pc=00000504", v1, pc1);
        end
        issue(JALR_X10_X5, 32'h600);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h404}) begin
            failed++; $display("FAIL jalr_rs1_x5_pop: got v=%b pc=%h want v=1 pc=00000404", v1, pc1);
        end
        issue(RET, 32'h900);
    endtask

    task automatic test_gating();
        issue(JAL_X1, 32'h100);
        drive(JAL_X1, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL gate_stall: got v=%b pc=%h want v=1 pc=00000104", v1, pc1);
        end
        drive(JAL_X1, 32'h700, 1'b1, 1'b0, 1'b1, 1'b0);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL gate_flush: got v=%b pc=%h want v=1 pc=00000104", v1, pc1);
        end
        drive(JAL_X1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL gate_bubble: got v=%b pc=%h want v=1 pc=00000104", v1, pc1);
        end
        drive(RET, 32'h700, 1'b1, 1'b1, 1'b0, 1'b0);
        issue(ADDI_NOP, 32'h704);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL gate_pop_stall_nop: got v=%b pc=%h want v=1 pc=00000104", v1, pc1);
        end
        drive(JAL_X1, 32'h800, 1'b1, 1'b0, 1'b0, 1'b1);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL gate_reset: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
    endtask

    task automatic test_rvc();
        issue(C_JAL, 32'h300);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h302}) begin
            failed++; $display("FAIL cjal_push: got v=%b pc=%h want v=1 pc=00000302", v1, pc1);
        end
        tests++;
        if ({v0, pc0} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL cjal_norvc: got v=%b pc=%h want v=0 pc=00000000", v0, pc0);
        end
        issue(C_JR_X1, 32'h380);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL cjr_pop: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
        issue(JAL_X1, 32'h100);
        issue(C_JR_X1, 32'h380);
        tests++;
        if ({v0, pc0} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL cjr_norvc: got v=%b pc=%h want v=1 pc=00000104", v0, pc0);
        end
        issue(C_JALR_X10, 32'h310);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h312}) begin
            failed++; $display("FAIL cjalr_push: got v=%b pc=%h want v=1 pc=00000312", v1, pc1);
        end
        issue(C_JALR_X1, 32'h320);
        issue(C_JR_X1, 32'h380);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL cjalr_swap: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
        tests++;
        if ({v0, pc0} !== {1'b1, 32'h104}) begin
            failed++; $display("FAIL cjalr_norvc: got v=%b pc=%h want v=1 pc=00000104", v0, pc0);
        end
        drive(ADDI_NOP, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        issue(JAL_X1, 32'hFFFF_FFFC);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h0}) begin
            failed++; $display("FAIL wrap32: got v=%b pc=%h want v=1 pc=00000000", v1, pc1);
        end
        issue(C_JAL, 32'hFFFF_FFFE);
        tests++;
        if ({v1, pc1} !== {1'b1, 32'h0}) begin
            failed++; $display("FAIL wrap16: got v=%b pc=%h want v=1 pc=00000000", v1, pc1);
        end
        issue(RET, 32'h900);
        issue(RET, 32'h900);
        tests++;
        if ({v1, pc1} !== {1'b0, 32'h0}) begin
            failed++; $display("FAIL wrap_drain: got v=%b pc=%h want v=0 pc=00000000", v1, pc1);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_swap();
        test_jalr_decode();
        test_gating();
        test_rvc();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/riscv_rsb.md
RISCV_RSB -- requirements
Module: riscv_rsb

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and address width.
REQ-002 SHALL have parameter RSB_DEPTH, default 4, number of stack entries (≥1).
REQ-003 SHALL have parameter HAS_RVC, default 0; non-zero enables compressed call/return decode.
REQ-004 SHALL have port clk_i input 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i input 1: reset, synchronous and active-high.
REQ-006 SHALL have port stall_i input 1: fetch stalled; no stack update.
REQ-007 SHALL have port flush_i input 1: pipeline flush from the branch unit; the current instruction is ignored.
REQ-008 SHALL have port if_valid_i input 1: if_insn_i/if_pc_i hold a real instruction (not a bubble).
REQ-009 SHALL have port if_pc_i input XLEN: PC of the fetched instruction.
REQ-010 SHALL have port if_insn_i input 32: fetched instruction word; a 16-bit instruction occupies bits [15:0].
REQ-011 SHALL have port rsb_pc_o output XLEN: predicted return address (top of stack); this feeds id_rsb_pc_i of the branch unit.
REQ-012 SHALL have port rsb_valid_o output 1: stack non-empty.

Function
REQ-013 SHALL treat a link register as x1 or x5.
REQ-014 SHALL set 32-bit decode when if_insn_i[1:0]==2'b11: JAL with rd=link => push.
REQ-015 SHALL decode JALR as: rd=link and rs1 not link => push; rd not link and rs1=link => pop; both link with rd!=rs1 => pop+push; both link with rd==rs1 => push; neither link => none.
REQ-016 SHALL, when HAS_RVC!=0 and [1:0]!=2'b11, decode: C.JAL (XLEN==32, funct3=001, op=01) => push; C.JALR (funct3=100, bit12=1, rs2=0, rs1!=0, op=10) => push if rs1 not link, pop+push otherwise; C.JR (funct3=100, bit12=0, rs2=0, rs1!=0, op=10) with rs1=link => pop; all else => none.
REQ-017 SHALL, when HAS_RVC==0, ignore instructions with [1:0]!=2'b11 (no operation).
REQ-018 SHALL compute the pushed value as if_pc_i+2 for 16-bit and if_pc_i+4 for 32-bit instructions, modulo 2^XLEN.
REQ-019 SHALL perform an operation only when if_valid_i=1, stall_i=0, flush_i=0 and rst_i=0.
REQ-020 SHALL store entries in a circular buffer with top pointer and count 0..RSB_DEPTH.
REQ-021 SHALL, on push with count<RSB_DEPTH, advance the pointer (wrapping RSB_DEPTH-1→0), write the value and increment count.
REQ-022 SHALL, on push when full, advance the pointer and overwrite the oldest entry; count stays RSB_DEPTH.
REQ-023 SHALL, on pop with count>0, retreat the pointer (wrapping 0→RSB_DEPTH-1) and decrement count.
REQ-024 SHALL make a pop on an empty stack a no-op.
REQ-025 SHALL, on pop+push, overwrite the top entry in place with count unchanged; when empty, behave as a plain push.
REQ-026 SHALL drive rsb_pc_o = entry at the top pointer when count>0, else all-zero; rsb_valid_o = (count!=0); both driven from registered state only.
REQ-027 SHALL provide one-cycle latency: an update sampled at edge N is visible on rsb_pc_o after edge N, and the instruction causing a pop sees the pre-pop top during its own cycle.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, set count=0, pointer=0 and all entries=0, overriding any simultaneous push/pop; outputs are then rsb_pc_o=0 and rsb_valid_o=0.
REQ-029 SHALL have no asynchronous state; before the first edge with rst_i=1 the outputs are undefined.

Verification
REQ-030 SHALL verify push/pop: JAL x1 at pc=0x100 → rsb_pc_o=0x104 and valid=1 next cycle; JALR x0,0(x1) → valid=0 and rsb_pc_o=0 next cycle.
REQ-031 SHALL verify overflow: with RSB_DEPTH=4, push at pc 0x10,0x20,0x30,0x40,0x50, then 5 pops → tops 0x54,0x44,0x34,0x24; after 4th pop valid=0; 5th pop no-op.
REQ-032 SHALL verify swap: stack [0x104], JALR x5,0(x1) at pc=0x200 → rsb_pc_o=0x204 with count still 1; same instruction on an empty stack → count=1 and top=0x204.
REQ-033 SHALL verify gating: push presented with stall_i=1, flush_i=1 or if_valid_i=0 → state unchanged; rst_i=1 with push pending → valid=0 and rsb_pc_o=0.
REQ-034 SHALL verify RVC: HAS_RVC=1, C.JAL at pc=0x300 → top=0x302; C.JR x1 → pop; with HAS_RVC=0 the same encodings have no effect.
REQ-035 SHALL verify wrap: pc=0xFFFF_FFFC with JAL x1 → top=0x0000_0000 (XLEN=32).
